inst_decode_stage: RTL and testbench
====================================

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clk and rst; no other clock or reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_inst / in_pc  input  32 / 32  instruction word / its PC.
REQ-007 rs1_data / rs2_data  input  32 / 32  register-file read data for in_inst[19:15] / in_inst[24:20], same cycle.
REQ-008 flush  input  1  discard held and incoming instruction.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-010 out_inst_opcode  output  20  one-hot ALU select: 19 lui, 18 auipc, 17 jal, 16 jalr, 15 beq, 14 bne, 13 blt, 12 bge, 11 bltu, 10 bgeu, 9 add, 8 sub, 7 sll, 6 sra, 5 srl, 4 slt, 3 sltu, 2 xor, 1 or, 0 and.
REQ-011 out_op1 / out_op2  output  32 / 32  ALU operands.
REQ-012 out_target  output  32  jump/branch target.
REQ-013 out_rd / out_rd_we  output  5 / 1  destination register / write enable.
REQ-014 out_mem_rd / out_mem_wr / out_store_data  output  1 / 1 / 32  load, store, store data (rs2_data).
REQ-015 out_illegal  output  1  unsupported encoding.

Function
REQ-016 SHALL register one decoded instruction (single-entry stage, latency 1 cycle): load when in_valid && in_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (combinational, full throughput).
REQ-018 out_valid SHALL set on load, clear when out_ready && no load; all out_* held stable while out_valid && !out_ready.
REQ-019 flush SHALL have priority: next cycle out_valid=0; input accepted that cycle dropped.
REQ-020 Immediates: I, S, B, U, J per RV32I, sign-extended to 32 bits; B/J bit0=0.
REQ-021 LUI: op1=0, op2=imm_u. AUIPC: op1=pc, op2=imm_u.
REQ-022 JAL: op1=pc, op2=imm_j, target=pc+imm_j. JALR: op1=pc, op2=imm_i, target=(rs1_data+imm_i)&~1.
REQ-023 Branches (funct3 000/001/100/101/110/111): op1=rs1_data, op2=rs2_data, target=pc+imm_b, rd_we=0.
REQ-024 OP-IMM: addi/slti/sltiu/xori/ori/andi op2=imm_i; slli/srli/srai op2={27'b0,imm_i[4:0]}; funct7 other than 0000000 (slli/srli) or 0100000 (srai) SHALL be illegal.
REQ-025 OP: op2=rs2_data, shifts op2={27'b0,rs2_data[4:0]}; funct7[5] selects sub/sra; any other funct7 bit set SHALL be illegal.
REQ-026 LOAD (funct3 000,001,010,100,101) / STORE (000,001,010): add, op1=rs1_data, op2=imm_i / imm_s; mem_rd / mem_wr=1; store rd_we=0.
REQ-027 All other encodings (incl. FENCE, SYSTEM, in_inst[1:0]!=11): out_illegal=1, opcode=0, rd_we=0, mem_rd=mem_wr=0.
REQ-028 rd_we SHALL be 0 when rd=x0; out_inst_opcode SHALL be one-hot or all-zero, never multi-hot.

Reset
REQ-029 On rst: out_valid=0, out_illegal=0, out_rd_we=0, out_mem_rd=out_mem_wr=0, out_inst_opcode=0, all data outputs 0; rst overrides flush and load.
REQ-030 in_ready SHALL be 1 in the cycle after reset deasserts; rst mid-stall discards the held instruction.

Structure
REQ-031 Shared package rv32i_pkg SHALL hold major-opcode constants, funct3/funct7 constants, one-hot bit indices of REQ-010.
REQ-032 Combinational sub-module imm_gen SHALL produce the five immediates from in_inst.

Verification
REQ-033 addi x1,x0,5 (0x00500093), rs1_data=0 -> next cycle out_valid=1, opcode bit9, op1=0, op2=5, rd=1, rd_we=1.
REQ-034 sub x3,x1,x2 (0x402081B3), rs1=7, rs2=2 -> opcode bit8, op1=7, op2=2, rd=3; srai x4,x1,3 (0x4030D213) -> bit6, op2=3.
REQ-035 beq x1,x2,+8 (0x00208463), pc=0x100 -> opcode bit15, target=0x108, rd_we=0; lui x5,0x12345 (0x123452B7) -> bit19, op1=0, op2=0x12345000.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next instruction loads same cycle, no loss or duplicate.
REQ-037 0xFFFFFFFF -> out_illegal=1, opcode=0, rd_we=0; flush with held instruction and in_valid=1 -> out_valid=0 next cycle, input dropped.
REQ-038 rst asserted while stalled -> all outputs zero next cycle, in_ready=1 after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I encoding constants, one-hot ALU select indices and the
// decoded-instruction record shared by the decode stage.
package rv32i_pkg;

   // Major opcodes (in_inst[6:0]); bits [1:0] are always 2'b11 here.
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct3 for OP / OP-IMM
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // funct3 for BRANCH
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct3 for LOAD / STORE
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // funct7
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Bit positions inside out_inst_opcode
   localparam int unsigned ALU_W = 20;
   localparam logic [4:0] ALU_LUI   = 5'd19;
   localparam logic [4:0] ALU_AUIPC = 5'd18;
   localparam logic [4:0] ALU_JAL   = 5'd17;
   localparam logic [4:0] ALU_JALR  = 5'd16;
   localparam logic [4:0] ALU_BEQ   = 5'd15;
   localparam logic [4:0] ALU_BNE   = 5'd14;
   localparam logic [4:0] ALU_BLT   = 5'd13;
   localparam logic [4:0] ALU_BGE   = 5'd12;
   localparam logic [4:0] ALU_BLTU  = 5'd11;
   localparam logic [4:0] ALU_BGEU  = 5'd10;
   localparam logic [4:0] ALU_ADD   = 5'd9;
   localparam logic [4:0] ALU_SUB   = 5'd8;
   localparam logic [4:0] ALU_SLL   = 5'd7;
   localparam logic [4:0] ALU_SRA   = 5'd6;
   localparam logic [4:0] ALU_SRL   = 5'd5;
   localparam logic [4:0] ALU_SLT   = 5'd4;
   localparam logic [4:0] ALU_SLTU  = 5'd3;
   localparam logic [4:0] ALU_XOR   = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd1;
   localparam logic [4:0] ALU_AND   = 5'd0;

   // Everything the stage registers for one instruction.
   typedef struct packed {
      logic [ALU_W-1:0] alu_sel;
      logic [31:0]      op1;
      logic [31:0]      op2;
      logic [31:0]      target;
      logic [4:0]       rd;
      logic             rd_we;
      logic             mem_rd;
      logic             mem_wr;
      logic [31:0]      store_data;
      logic             illegal;
   } dec_t;

   // One-hot select for an ALU bit index.
   function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] idx);
      return {{(ALU_W-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Base (funct7 = 0) ALU operation for an OP / OP-IMM funct3.
   function automatic logic [4:0] op_alu(input logic [2:0] f3);
      logic [4:0] idx;
      case (f3)
         F3_ADD:  idx = ALU_ADD;
         F3_SLL:  idx = ALU_SLL;
         F3_SLT:  idx = ALU_SLT;
         F3_SLTU: idx = ALU_SLTU;
         F3_XOR:  idx = ALU_XOR;
         F3_SR:   idx = ALU_SRL;
         F3_OR:   idx = ALU_OR;
         default: idx = ALU_AND;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: the five RV32I immediates, sign-extended, from one instruction word.
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:0] inst,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: single-entry RV32I decode register between fetch and
// execute. Decodes in the accept cycle, presents the result one cycle later.
module inst_decode_stage
   import rv32i_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       rs1_data,
   input  logic [31:0]       rs2_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ALU_W-1:0]  out_inst_opcode,
   output logic [31:0]       out_op1,
   output logic [31:0]       out_op2,
   output logic [31:0]       out_target,
   output logic [4:0]        out_rd,
   output logic              out_rd_we,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [31:0]       out_store_data,
   output logic              out_illegal
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   dec_t        dec_new;
   logic        bad;
   logic        writes;

   logic        valid_d, valid_q;
   dec_t        dec_d, dec_q;
   logic        load;

   assign opc = in_inst[6:0];
   assign f3  = in_inst[14:12];
   assign f7  = in_inst[31:25];
   assign rd  = in_inst[11:7];

   imm_gen u_imm_gen (
      .inst  (in_inst),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // Decode the incoming word into operands, ALU select and side effects.
   always_comb begin
      dec_new = '0;
      bad     = 1'b0;
      writes  = 1'b0;
      case (opc)
         OPC_LUI: begin
            dec_new.alu_sel = alu_onehot(ALU_LUI);
            dec_new.op2     = imm_u;
            writes          = 1'b1;
         end
         OPC_AUIPC: begin
            dec_new.alu_sel = alu_onehot(ALU_AUIPC);
            dec_new.op1     = in_pc;
            dec_new.op2     = imm_u;
            writes          = 1'b1;
         end
         OPC_JAL: begin
            dec_new.alu_sel = alu_onehot(ALU_JAL);
            dec_new.op1     = in_pc;
            dec_new.op2     = imm_j;
            dec_new.target  = in_pc + imm_j;
            writes          = 1'b1;
         end
         OPC_JALR: begin
            // Only funct3 = 000 is a defined JALR encoding.
            if (f3 == 3'b000) begin
               dec_new.alu_sel = alu_onehot(ALU_JALR);
               dec_new.op1     = in_pc;
               dec_new.op2     = imm_i;
               dec_new.target  = (rs1_data + imm_i) & 32'hFFFF_FFFE;
               writes          = 1'b1;
            end else begin
               bad = 1'b1;
            end
         end
         OPC_BRANCH: begin
            dec_new.op1    = rs1_data;
            dec_new.op2    = rs2_data;
            dec_new.target = in_pc + imm_b;
            case (f3)
               F3_BEQ:  dec_new.alu_sel = alu_onehot(ALU_BEQ);
               F3_BNE:  dec_new.alu_sel = alu_onehot(ALU_BNE);
               F3_BLT:  dec_new.alu_sel = alu_onehot(ALU_BLT);
               F3_BGE:  dec_new.alu_sel = alu_onehot(ALU_BGE);
               F3_BLTU: dec_new.alu_sel = alu_onehot(ALU_BLTU);
               F3_BGEU: dec_new.alu_sel = alu_onehot(ALU_BGEU);
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_new.alu_sel = alu_onehot(ALU_ADD);
            dec_new.op1     = rs1_data;
            dec_new.op2     = imm_i;
            dec_new.mem_rd  = 1'b1;
            writes          = 1'b1;
            if (!(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
               bad = 1'b1;
         end
         OPC_STORE: begin
            dec_new.alu_sel    = alu_onehot(ALU_ADD);
            dec_new.op1        = rs1_data;
            dec_new.op2        = imm_s;
            dec_new.mem_wr     = 1'b1;
            dec_new.store_data = rs2_data;
            if (!(f3 inside {F3_LB, F3_LH, F3_LW}))
               bad = 1'b1;
         end
         OPC_OPIMM: begin
            dec_new.op1 = rs1_data;
            dec_new.op2 = imm_i;
            writes      = 1'b1;
            if (f3 == F3_SLL) begin
               dec_new.op2 = {27'b0, imm_i[4:0]};
               if (f7 == F7_BASE) dec_new.alu_sel = alu_onehot(ALU_SLL);
               else               bad = 1'b1;
            end else if (f3 == F3_SR) begin
               dec_new.op2 = {27'b0, imm_i[4:0]};
               if (f7 == F7_BASE)     dec_new.alu_sel = alu_onehot(ALU_SRL);
               else if (f7 == F7_ALT) dec_new.alu_sel = alu_onehot(ALU_SRA);
               else                   bad = 1'b1;
            end else begin
               dec_new.alu_sel = alu_onehot(op_alu(f3));
            end
         end
         OPC_OP: begin
            dec_new.op1 = rs1_data;
            dec_new.op2 = (f3 == F3_SLL || f3 == F3_SR) ? {27'b0, rs2_data[4:0]} : rs2_data;
            writes      = 1'b1;
            // funct7[5] is only meaningful for add->sub and srl->sra.
            if (f7 == F7_BASE)                     dec_new.alu_sel = alu_onehot(op_alu(f3));
            else if (f7 == F7_ALT && f3 == F3_ADD) dec_new.alu_sel = alu_onehot(ALU_SUB);
            else if (f7 == F7_ALT && f3 == F3_SR)  dec_new.alu_sel = alu_onehot(ALU_SRA);
            else                                   bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase

      // Illegal words carry no side effects; rd is only reported for writers.
      if (bad) begin
         dec_new         = '0;
         dec_new.illegal = 1'b1;
      end else if (writes) begin
         dec_new.rd    = rd;
         dec_new.rd_we = (rd != 5'd0);
      end
   end

   assign in_ready = !valid_q || out_ready;
   assign load     = in_valid && in_ready;

   // Next state of the single entry: flush beats load, load beats drain.
   always_comb begin
      valid_d = valid_q;
      dec_d   = dec_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         dec_d   = dec_new;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Stage register; reset clears the entry and all presented data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dec_q   <= dec_d;
      end
   end

   assign out_valid       = valid_q;
   assign out_inst_opcode = dec_q.alu_sel;
   assign out_op1         = dec_q.op1;
   assign out_op2         = dec_q.op2;
   assign out_target      = dec_q.target;
   assign out_rd          = dec_q.rd;
   assign out_rd_we       = dec_q.rd_we;
   assign out_mem_rd      = dec_q.mem_rd;
   assign out_mem_wr      = dec_q.mem_wr;
   assign out_store_data  = dec_q.store_data;
   assign out_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: directed vectors plus randomized traffic; a negedge
// monitor compares the presented entry against a queue of expected decodes.
module tb_inst_decode_stage;

   typedef logic [156:0] resp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, rs1_data, rs2_data;
   logic [19:0] out_inst_opcode;
   logic [31:0] out_op1, out_op2, out_target, out_store_data;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_mem_rd, out_mem_wr, out_illegal;

   int    total = 0;
   int    bad   = 0;
   resp_t q[$];
   bit    rst_seen = 1'b0;
   resp_t dut_resp;

   inst_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst_opcode(out_inst_opcode), .out_op1(out_op1), .out_op2(out_op2),
      .out_target(out_target), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_store_data(out_store_data), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   assign dut_resp = {out_inst_opcode, out_op1, out_op2, out_target, out_rd,
                      out_rd_we, out_mem_rd, out_mem_wr, out_store_data, out_illegal};

   task automatic chk(input string nm, input resp_t act, input resp_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference decode: classify by mnemonic, then assemble the result.
   function automatic resp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
      int          tbl [8] = '{9, 7, 4, 3, 2, 5, 1, 0};
      int          brt [8] = '{15, 14, -1, -1, 13, 12, 11, 10};
      int          alu = -1;
      int          i_imm, s_imm, b_imm, j_imm;
      logic [31:0] u_imm, a, b, t, sd;
      logic        wr, mr, mw;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25]; rd = inst[11:7];
      i_imm = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
      s_imm = int'({inst[31:25], inst[11:7]}) - (inst[31] ? 4096 : 0);
      b_imm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
              + int'(inst[11:8]) * 2;
      j_imm = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
              + int'(inst[30:21]) * 2;
      u_imm = {inst[31:12], 12'h000};
      a = 0; b = 0; t = 0; sd = 0; wr = 0; mr = 0; mw = 0;
      case (op)
         7'h37: begin alu = 19; b = u_imm; wr = 1; end
         7'h17: begin alu = 18; a = pc; b = u_imm; wr = 1; end
         7'h6F: begin alu = 17; a = pc; b = 32'(j_imm); t = pc + 32'(j_imm); wr = 1; end
         7'h67: if (f3 == 0) begin
                   alu = 16; a = pc; b = 32'(i_imm); t = (r1 + 32'(i_imm)) & ~32'd1; wr = 1;
                end
         7'h63: begin alu = brt[f3]; a = r1; b = r2; t = pc + 32'(b_imm); end
         7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin
                   alu = 9; a = r1; b = 32'(i_imm); mr = 1; wr = 1;
                end
         7'h23: if (f3 <= 2) begin
                   alu = 9; a = r1; b = 32'(s_imm); mw = 1; sd = r2;
                end
         7'h13: begin
            a = r1; b = 32'(i_imm); wr = 1;
            if (f3 == 1) begin
               b = {27'd0, inst[24:20]}; alu = (f7 == 0) ? 7 : -1;
            end else if (f3 == 5) begin
               b = {27'd0, inst[24:20]}; alu = (f7 == 0) ? 5 : (f7 == 7'h20) ? 6 : -1;
            end else alu = tbl[f3];
         end
         7'h33: begin
            a = r1; b = (f3 == 1 || f3 == 5) ? {27'd0, r2[4:0]} : r2; wr = 1;
            if (f7 == 0) alu = tbl[f3];
            else if (f7 == 7'h20 && f3 == 0) alu = 8;
            else if (f7 == 7'h20 && f3 == 5) alu = 6;
         end
         default: ;
      endcase
      if (alu < 0) return resp_t'(1);
      return {20'(32'd1 << alu), a, b, t, wr ? rd : 5'd0, wr && rd != 0, mr, mw, sd, 1'b0};
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
      logic [31:0] w = $urandom;
      int unsigned s = $urandom_range(0, 10);
      if (s < 9) w[6:0] = opcs[s];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   // Monitor: check presented entry, then advance the expected queue by what
   // the next rising edge will do with the inputs visible now.
   always @(negedge clk) begin
      if (rst_seen) chk("reset_outputs", {dut_resp, out_valid}, '0);
      chk("valid", resp_t'(out_valid), resp_t'(q.size() != 0));
      chk("in_ready", resp_t'(in_ready), resp_t'(q.size() == 0 || out_ready));
      if (out_valid && q.size() != 0) begin
         chk("decode", dut_resp, q[0]);
         chk("onehot_rdwe", resp_t'($countones(out_inst_opcode) > 1 || (out_rd_we && out_rd == 0)),
             '0);
      end
      if (rst) q.delete();
      else begin
         if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
         if (flush) q.delete();
         else if (in_valid && in_ready) q.push_back(model(in_inst, in_pc, rs1_data, rs2_data));
      end
      rst_seen = rst;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; in_inst = i; in_pc = p; rs1_data = a; rs2_data = b;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1; in_valid = 0; out_ready = 0; flush = 0;
      in_inst = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
      repeat (2) cyc();
      rst = 0;
      @(negedge clk);
      chk("rst_out_valid", resp_t'(out_valid), '0);
      chk("rst_in_ready", resp_t'(in_ready), resp_t'(1));
      chk("rst_data", dut_resp, '0);

      out_ready = 1;
      issue(32'h00500093, 32'h0, 32'h0, 32'h0);                 // addi x1,x0,5
      chk("addi_valid", resp_t'(out_valid), resp_t'(1));
      chk("addi_opc", resp_t'(out_inst_opcode), resp_t'(20'h00200));
      chk("addi_ops", {out_op1, out_op2}, {32'd0, 32'd5});
      chk("addi_rd", {out_rd, out_rd_we}, {5'd1, 1'b1});

      issue(32'h402081B3, 32'h4, 32'd7, 32'd2);                 // sub x3,x1,x2
      chk("sub_opc", resp_t'(out_inst_opcode), resp_t'(20'h00100));
      chk("sub_ops", {out_op1, out_op2, out_rd}, {32'd7, 32'd2, 5'd3});

      issue(32'h4030D213, 32'h8, 32'h80, 32'h0);                // srai x4,x1,3
      chk("srai", {out_inst_opcode, out_op2}, {20'h00040, 32'd3});

      issue(32'h00208463, 32'h100, 32'd5, 32'd5);               // beq x1,x2,+8
      chk("beq", {out_inst_opcode, out_target, out_rd_we}, {20'h08000, 32'h108, 1'b0});

      issue(32'h123452B7, 32'h0, 32'd9, 32'd9);                 // lui x5,0x12345
      chk("lui", {out_inst_opcode, out_op1, out_op2}, {20'h80000, 32'd0, 32'h12345000});

      issue(32'hFFFFFFFF, 32'h0, 32'd1, 32'd1);
      chk("illegal", {out_illegal, out_inst_opcode, out_rd_we, out_mem_rd, out_mem_wr},
          {1'b1, 20'h0, 3'b000});

      // Stall for three cycles with a second instruction waiting.
      cyc();
      out_ready = 0; in_valid = 1; in_inst = 32'h00500093; rs1_data = 0;
      cyc();
      in_inst = 32'h00A00113;                                   // addi x2,x0,10
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_ready", resp_t'(in_ready), '0);
         chk("stall_hold", {out_valid, out_op2, out_rd}, {1'b1, 32'd5, 5'd1});
         cyc();
      end
      out_ready = 1;
      cyc();
      in_valid = 0;
      @(negedge clk);
      chk("release_next", {out_valid, out_op2, out_rd}, {1'b1, 32'd10, 5'd2});

      // Flush with a held entry and a new instruction on the input.
      cyc();
      out_ready = 0; in_valid = 1; in_inst = 32'h00500093;
      cyc();
      in_inst = 32'h00700193; flush = 1;
      @(negedge clk);
      chk("flush_pre", resp_t'(out_valid), resp_t'(1));
      cyc();
      flush = 0; in_valid = 0;
      @(negedge clk);
      chk("flush_valid", resp_t'(out_valid), '0);
      cyc();
      @(negedge clk);
      chk("flush_drop", resp_t'(out_valid), '0);

      // Reset while stalled.
      cyc();
      in_valid = 1; in_inst = 32'h00500093;
      cyc();
      in_inst = 32'h00A00113;
      cyc();
      rst = 1;
      cyc();
      rst = 0; in_valid = 0;
      @(negedge clk);
      chk("rst_stall_zero", {dut_resp, out_valid}, '0);
      chk("rst_stall_ready", resp_t'(in_ready), resp_t'(1));

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 3);
         rst       = ($urandom_range(0, 99) < 1);
         in_inst   = gen_inst();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         rs1_data  = $urandom;
         rs2_data  = $urandom;
      end
      cyc();
      in_valid = 0; flush = 0; rst = 0; out_ready = 1;
      repeat (3) cyc();
      @(negedge clk);
      chk("drain_empty", resp_t'(q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
